// File: rtl/cordic_sincos_iter.sv
// cordic_sincos_iter: iterative CORDIC sine/cosine, one micro-rotation per clock.
// The angle is folded into [-90,+90] degrees on acceptance, and the result is negated afterwards to compensate.
module cordic_sincos_iter #(
  parameter int DATA_W     = 20,
  parameter int ANGLE_W    = 20,
  parameter int ANGLE_FRAC = 4,
  parameter int ITER       = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic signed [ANGLE_W-1:0] angle,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic signed [DATA_W-1:0]  cos_out,
  output logic signed [DATA_W-1:0]  sin_out
);
  localparam int FB = DATA_W - 4;
  // atan(2^-i) in degrees scaled by 2^16; rescaled to ANGLE_FRAC with rounding
  localparam logic [31:0] ATAN_Q16 [16] = '{
    32'd2949120, 32'd1740967, 32'd919879, 32'd466945,
    32'd234379,  32'd117304,  32'd58666,  32'd29335,
    32'd14668,   32'd7334,    32'd3667,   32'd1833,
    32'd917,     32'd458,     32'd229,    32'd115
  };
  // aggregate CORDIC gain K for n iterations, scaled by 2^30
  function automatic logic [31:0] k_q30(input int n);
    return n <= 4  ? 32'd653730436 :
           n == 5  ? 32'd652457340 :
           n == 6  ? 32'd652138998 :
           n == 7  ? 32'd652059411 :
           n == 8  ? 32'd652039504 :
           n == 9  ? 32'd652034533 :
           n == 10 ? 32'd652033288 :
           n == 11 ? 32'd652032977 :
           n == 12 ? 32'd652032902 : 32'd652032881;
  endfunction
  localparam logic [63:0] K_Q30 = 64'(k_q30(ITER));
  localparam logic signed [DATA_W-1:0] X0 = DATA_W'((((K_Q30 << 1) >> (30 - FB)) + 64'd1) >> 1);
  localparam logic signed [ANGLE_W-1:0] A90  = ANGLE_W'(90 * (2 ** ANGLE_FRAC));
  localparam logic signed [ANGLE_W-1:0] A180 = ANGLE_W'(180 * (2 ** ANGLE_FRAC));
  localparam logic [3:0] LAST = 4'(ITER - 1);

  typedef enum logic [1:0] {IDLE, ROT, FIN} state_t;

  state_t                    r_state;
  logic [3:0]                r_cnt;
  logic signed [DATA_W-1:0]  r_x, r_y;
  logic signed [ANGLE_W-1:0] r_z;
  logic                      r_neg, r_oor;

  logic                      w_hi, w_lo, w_oor, w_d;
  logic signed [ANGLE_W-1:0] w_fold, w_atan;
  logic signed [DATA_W-1:0]  w_xs, w_ys;
  logic [31:0]               w_atan_q;

  always_comb begin
    w_hi     = angle > A90;
    w_lo     = angle < -A90;
    w_oor    = (angle > A180) || (angle < -A180);
    w_fold   = w_hi ? angle - A180 : w_lo ? angle + A180 : angle;
    w_atan_q = ATAN_Q16[r_cnt];
    w_atan   = ANGLE_W'((((w_atan_q << 1) >> (16 - ANGLE_FRAC)) + 32'd1) >> 1);
    w_d      = ~r_z[ANGLE_W-1];
    w_xs     = r_x >>> r_cnt;
    w_ys     = r_y >>> r_cnt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_neg   <= 1'b0;
      r_oor   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      cos_out <= '0;
      sin_out <= '0;
    end else begin
      done <= 1'b0;
      if (r_state == ROT) begin
        r_x   <= w_d ? r_x - w_ys : r_x + w_ys;
        r_y   <= w_d ? r_y + w_xs : r_y - w_xs;
        r_z   <= w_d ? r_z - w_atan : r_z + w_atan;
        r_cnt <= r_cnt + 4'd1;
        if (r_cnt == LAST) begin
          r_state <= FIN;
          busy    <= 1'b0;
        end
      end else begin
        if (r_state == FIN) begin
          done    <= 1'b1;
          err     <= r_oor;
          cos_out <= r_oor ? '0 : r_neg ? -r_x : r_x;
          sin_out <= r_oor ? '0 : r_neg ? -r_y : r_y;
        end
        r_state <= start ? ROT : IDLE;
        if (start) begin
          busy  <= 1'b1;
          r_cnt <= '0;
          r_x   <= X0;
          r_y   <= '0;
          r_z   <= w_fold;
          r_neg <= w_hi | w_lo;
          r_oor <= w_oor;
        end
      end
    end
  end
endmodule

// File: tb/tb_cordic_sincos_iter.sv
// tb_cordic_sincos_iter: directed bench with a queue scoreboard fed by a cycle model of the request protocol.
module tb_cordic_sincos_iter;
  localparam int ITER = 12;
  localparam int TOL  = 262;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic signed [19:0] angle = '0;
  logic busy, done, err;
  logic signed [19:0] cos_out, sin_out;

  logic start8 = 1'b0;
  logic signed [19:0] angle8 = '0;
  logic busy8, done8, err8;
  logic signed [23:0] cos8, sin8;

  int errors = 0, checks = 0;

  typedef struct {logic e; real c; real s;} exp_t;
  exp_t sb[$];

  int   m_st = 0, m_cnt = 0;
  logic m_done = 1'b0, m_busy = 1'b0;

  always #5 clk = ~clk;

  cordic_sincos_iter u_dut (
    .clk(clk), .rst(rst), .start(start), .angle(angle),
    .busy(busy), .done(done), .err(err), .cos_out(cos_out), .sin_out(sin_out)
  );

  cordic_sincos_iter #(.DATA_W(24), .ITER(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .angle(angle8),
    .busy(busy8), .done(done8), .err(err8), .cos_out(cos8), .sin_out(sin8)
  );

  task automatic chk_eq(input string tag, input longint obs, input longint expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, obs, expv);
    end
  endtask

  task automatic chk_tol(input string tag, input longint obs, input real expv, input real tol);
    checks++;
    assert ((real'(obs) - expv) <= tol && (expv - real'(obs)) <= tol) else begin
      errors++;
      $error("FAIL %s: got %0d want %0.1f +/- %0.1f", tag, obs, expv, tol);
    end
  endtask

  function automatic exp_t mk(input int a);
    exp_t r;
    real rad;
    rad = (a / 16.0) * 3.141592653589793 / 180.0;
    r.e = (a > 2880) || (a < -2880);
    r.c = r.e ? 0.0 : $cos(rad) * 65536.0;
    r.s = r.e ? 0.0 : $sin(rad) * 65536.0;
    return r;
  endfunction

  // reference protocol model: idle/fin=0/2 accept start, rot=1 counts ITER steps
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_st = 0; m_cnt = 0; m_done = 1'b0; m_busy = 1'b0;
      sb.delete();
    end else begin
      m_done = (m_st == 2);
      if (m_st == 1) begin
        if (m_cnt == ITER - 1) begin m_st = 2; m_busy = 1'b0; end
        else m_cnt++;
      end else if (start) begin
        sb.push_back(mk(int'(angle)));
        m_st = 1; m_cnt = 0; m_busy = 1'b1;
      end else m_st = 0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      exp_t e;
      chk_eq("done", longint'(done), longint'(m_done));
      chk_eq("busy", longint'(busy), longint'(m_busy));
      if (done) begin
        if (sb.size() == 0) chk_eq("sb_underflow", sb.size(), 1);
        else begin
          e = sb.pop_front();
          chk_eq("err", longint'(err), longint'(e.e));
          chk_tol("cos", cos_out, e.c, e.e ? 0.0 : TOL);
          chk_tol("sin", sin_out, e.s, e.e ? 0.0 : TOL);
        end
      end
    end
  end

  task automatic run(input int a);
    int lat = 0;
    @(negedge clk);
    start = 1'b1;
    angle = 20'(a);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      lat++;
      start = 1'b0;
      if (done) break;
    end
    chk_eq($sformatf("latency_%0d", a), lat, ITER + 2);
    @(negedge clk);
    #1;
    chk_eq("drain", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat8 = 0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("rst_busy", longint'(busy), 0);
    chk_eq("rst_done", longint'(done), 0);
    chk_eq("rst_err", longint'(err), 0);
    chk_eq("rst_cos", cos_out, 0);
    chk_eq("rst_sin", sin_out, 0);
    rst = 1'b1;

    run(480);
    run(2400);
    run(-2400);
    run(1440);
    run(-1440);
    run(2880);
    run(-2880);
    run(2896);
    chk_eq("hold_err", longint'(err), 1);
    chk_eq("hold_cos", cos_out, 0);
    run(0);
    run(2881);
    run(-2881);
    run(720);

    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 40; k++) begin
      angle = 20'($urandom_range(0, 5760) - 2880);
      @(negedge clk);
    end
    start = 1'b0;
    for (int k = 0; k < 40 && (sb.size() != 0 || m_st != 0); k++) @(negedge clk);
    #1;
    chk_eq("b2b_drain", sb.size(), 0);

    @(negedge clk);
    start = 1'b1;
    angle = 20'sd480;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk_eq("mid_rst_busy", longint'(busy), 0);
    chk_eq("mid_rst_done", longint'(done), 0);
    chk_eq("mid_rst_cos", cos_out, 0);
    chk_eq("mid_rst_sin", sin_out, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    repeat (20) @(negedge clk);
    run(-480);

    @(negedge clk);
    start8 = 1'b1;
    angle8 = -20'sd720;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      lat8++;
      start8 = 1'b0;
      if (done8) break;
    end
    chk_eq("lat8", lat8, 10);
    chk_eq("err8", longint'(err8), 0);
    chk_tol("cos8", cos8, 0.70710678 * 1048576.0, 0.02 * 1048576.0);
    chk_tol("sin8", sin8, -0.70710678 * 1048576.0, 0.02 * 1048576.0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
